lif_neuron_param_loader_multi: RTL
==================================

Name: lif_neuron_param_loader_multi

Overview:
- Serial parameter loader for an array of NUM_NEURONS LIF neurons. Field widths are parametrised.
- Each serial frame has an address header, so it can target one neuron or broadcast to all of them.
- Parameters are staged in a shadow register and committed atomically on the last frame bit. Active parameters never show partial values.
- Sits between the chip-level serial pins and the LIF neuron array. Drives flattened per-neuron parameter buses.

Parameters:
- NUM_NEURONS, 4, number of neuron parameter sets (1..128).
- W_WEIGHT, 3, width of weight_a and weight_b (1..8).
- W_LEAK, 8, width of leak_rate (1..8).
- W_THRESH, 8, width of threshold (1..8).
- W_CYC, 4, width of leak_cycles (1..8).
- DEF_WA / DEF_WB / DEF_LEAK / DEF_THRESH / DEF_CYC, 2 / 2 / 2 / 30 / 2, reset value of every neuron's set.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  clock enable; when low, all state and outputs hold and inputs are ignored
- serial_data_in  in  1  serial bit, MSB first
- load_enable  in  1  frame gate; high for the whole frame
- weight_a_flat  out  NUM_NEURONS*W_WEIGHT  neuron i at [i*W_WEIGHT +: W_WEIGHT]
- weight_b_flat  out  NUM_NEURONS*W_WEIGHT  same packing as weight_a_flat
- leak_rate_flat  out  NUM_NEURONS*W_LEAK  per-neuron leak rate
- threshold_flat  out  NUM_NEURONS*W_THRESH  per-neuron threshold
- leak_cycles_flat  out  NUM_NEURONS*W_CYC  per-neuron leak cycles
- params_ready  out  1  high when no frame is in progress
- frame_done  out  1  one-cycle pulse after a successful commit
- frame_error  out  1  one-cycle pulse on abort, bad address or parity fail

Behaviour:
- Reset (asynchronous, active-high):
  - all neurons take the DEF_* values
  - params_ready=1, frame_done=0, frame_error=0
  - state IDLE; shift register, bit counter and field index cleared
- Actions below occur only on cycles with enable=1.
- Frame format: 8-bit header, then five 8-bit fields in order WA, WB, LEAK, THRESH, CYC. All bytes MSB first, 48 bits total.
  - Header bit7 = broadcast. Header bits[6:0] = neuron address.
  - Each field byte is truncated to its LSBs at that field's parameter width.
- States: IDLE, HEADER, FIELD, WAIT_RELEASE.
- IDLE:
  - load_enable=1 -> HEADER; params_ready<=0; counters cleared.
  - No bit is sampled on the transition cycle.
- HEADER and FIELD:
  - Each cycle with load_enable=1 shifts in one bit.
  - After 8 bits in HEADER, latch the header -> FIELD with field index 0.
  - After 8 bits in a field, write the field to the shadow register; field index +1.
- 48th bit sampled (field 4, bit 7):
  - Same edge: if the address is valid, copy shadow to the active set(s). A broadcast updates all neurons.
  - Next cycle: frame_done=1 on a valid commit, otherwise frame_error=1.
  - params_ready<=1 on that same edge; state -> WAIT_RELEASE.
- Address valid means broadcast=1 or addr<NUM_NEURONS. An invalid address still consumes the full frame but commits nothing.
- WAIT_RELEASE: load_enable=0 -> IDLE. Further bits are ignored, so a new frame needs load_enable low for at least one enabled cycle.
- Abort: load_enable=0 during HEADER or FIELD -> IDLE, frame_error pulse, params_ready<=1. Active sets are unchanged and the shadow is discarded.
- Reset mid-frame: immediate return to defaults, with no commit and no pulse.
- frame_done and frame_error are mutually exclusive. Each is high for exactly one cycle.

Optional Feature:
- Macro: LIF_LOADER_PARITY_EN.
- Defined:
  - the frame carries a 49th bit, even parity over all 48 preceding bits
  - commit happens on the 49th bit, and only if parity and address are both good
  - otherwise frame_error pulses
- Undefined: 48-bit frame as described above, no parity logic.

Decomposition:
- Package lif_loader_pkg holds:
  - the state encoding enum
  - field index constants FLD_WA=0 .. FLD_CYC=4
  - HDR_BITS=8, FIELD_BITS=8, NUM_FIELDS=5
  - the broadcast bit position (7)
- Sub-module lif_param_bank:
  - one neuron's active register set with async-reset defaults
  - commit strobe plus shadow inputs
  - instantiated NUM_NEURONS times by a generate loop

Test Plan:
- Default parameters: reset, then idle 10 cycles -> every neuron reads 2/2/2/30/2, params_ready=1, no pulses.
- Addressed write: NUM_NEURONS=4, frame 0x02,0x05,0x03,0x10,0x40,0x07 -> neuron 2 = 5/3/0x10/0x40/7, others stay at defaults, frame_done pulses once, params_ready drops during the frame.
- Broadcast and truncation: frame 0x80,0xFF,0x09,0x01,0xC8,0x1F -> all neurons get WA=7, WB=1, LEAK=1, THRESH=200, CYC=15.
- Abort and bad address: drop load_enable after 20 bits -> frame_error pulses, active sets unchanged. Header 0x05 with NUM_NEURONS=4 -> full frame consumed, frame_error pulses, no change.
- Hold and reset: toggle enable low for 3 cycles mid-frame -> same result as an uninterrupted frame. Assert reset at bit 30 -> defaults restored, state IDLE.
- Parity (LIF_LOADER_PARITY_EN): correct parity bit -> commit. Flipped parity bit -> frame_error and no change.

Source files
------------

// File: rtl/lif_loader_pkg.sv
// lif_loader_pkg: shared definitions for the LIF neuron serial parameter loader.
//   - state_e      : loader FSM state encoding
//   - FLD_*        : field index of each parameter byte within a frame
//   - HDR_BITS / FIELD_BITS / NUM_FIELDS : frame geometry
//   - BCAST_BIT    : header bit selecting broadcast to every neuron
package lif_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE         = 2'd0,
      ST_HEADER       = 2'd1,
      ST_FIELD        = 2'd2,
      ST_WAIT_RELEASE = 2'd3
   } state_e;

   localparam int HDR_BITS   = 8;
   localparam int FIELD_BITS = 8;
   localparam int NUM_FIELDS = 5;
   localparam int BCAST_BIT  = 7;

   localparam logic [2:0] FLD_WA     = 3'd0;
   localparam logic [2:0] FLD_WB     = 3'd1;
   localparam logic [2:0] FLD_LEAK   = 3'd2;
   localparam logic [2:0] FLD_THRESH = 3'd3;
   localparam logic [2:0] FLD_CYC    = 3'd4;

endpackage

// File: rtl/lif_neuron_param_loader_multi_if.sv
// lif_neuron_param_loader_multi_if: serial load port and frame status.
//   serial_data_in : serial bit, MSB first
//   load_enable    : frame gate, high for the whole frame
//   params_ready   : no frame in progress
//   frame_done     : one-cycle pulse after a successful commit
//   frame_error    : one-cycle pulse on abort / bad address / parity fail
// master = serial source, slave = loader.
interface lif_neuron_param_loader_multi_if;
   logic serial_data_in;
   logic load_enable;
   logic params_ready;
   logic frame_done;
   logic frame_error;

   modport master (
      output serial_data_in, load_enable,
      input  params_ready, frame_done, frame_error
   );

   modport slave (
      input  serial_data_in, load_enable,
      output params_ready, frame_done, frame_error
   );
endinterface

// File: rtl/lif_param_bank.sv
// lif_param_bank: one neuron's active parameter set.
//   clk, reset  : clock, async active-high reset (loads DEF_* values)
//   commit      : single-cycle strobe copying the sh_* inputs into the set
//   sh_*        : staged values to commit
//   wa..cyc     : active parameters
module lif_param_bank #(
   parameter int W_WEIGHT   = 3,
   parameter int W_LEAK     = 8,
   parameter int W_THRESH   = 8,
   parameter int W_CYC      = 4,
   parameter int DEF_WA     = 2,
   parameter int DEF_WB     = 2,
   parameter int DEF_LEAK   = 2,
   parameter int DEF_THRESH = 30,
   parameter int DEF_CYC    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                commit,
   input  logic [W_WEIGHT-1:0] sh_wa,
   input  logic [W_WEIGHT-1:0] sh_wb,
   input  logic [W_LEAK-1:0]   sh_leak,
   input  logic [W_THRESH-1:0] sh_thresh,
   input  logic [W_CYC-1:0]    sh_cyc,
   output logic [W_WEIGHT-1:0] wa,
   output logic [W_WEIGHT-1:0] wb,
   output logic [W_LEAK-1:0]   leak,
   output logic [W_THRESH-1:0] thresh,
   output logic [W_CYC-1:0]    cyc
);

   localparam logic [W_WEIGHT-1:0] RST_WA     = W_WEIGHT'(DEF_WA);
   localparam logic [W_WEIGHT-1:0] RST_WB     = W_WEIGHT'(DEF_WB);
   localparam logic [W_LEAK-1:0]   RST_LEAK   = W_LEAK'(DEF_LEAK);
   localparam logic [W_THRESH-1:0] RST_THRESH = W_THRESH'(DEF_THRESH);
   localparam logic [W_CYC-1:0]    RST_CYC    = W_CYC'(DEF_CYC);

   logic [W_WEIGHT-1:0] wa_q, wa_d, wb_q, wb_d;
   logic [W_LEAK-1:0]   leak_q, leak_d;
   logic [W_THRESH-1:0] thresh_q, thresh_d;
   logic [W_CYC-1:0]    cyc_q, cyc_d;

   always_comb begin
      wa_d     = wa_q;
      wb_d     = wb_q;
      leak_d   = leak_q;
      thresh_d = thresh_q;
      cyc_d    = cyc_q;
      if (commit) begin
         wa_d     = sh_wa;
         wb_d     = sh_wb;
         leak_d   = sh_leak;
         thresh_d = sh_thresh;
         cyc_d    = sh_cyc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wa_q     <= RST_WA;
         wb_q     <= RST_WB;
         leak_q   <= RST_LEAK;
         thresh_q <= RST_THRESH;
         cyc_q    <= RST_CYC;
      end else begin
         wa_q     <= wa_d;
         wb_q     <= wb_d;
         leak_q   <= leak_d;
         thresh_q <= thresh_d;
         cyc_q    <= cyc_d;
      end
   end

   assign wa     = wa_q;
   assign wb     = wb_q;
   assign leak   = leak_q;
   assign thresh = thresh_q;
   assign cyc    = cyc_q;

endmodule

// File: rtl/lif_neuron_param_loader_multi.sv
// lif_neuron_param_loader_multi: serial, addressed parameter loader for an
// array of NUM_NEURONS LIF neurons.
//   clk, reset  : clock, async active-high reset (all neurons to DEF_*)
//   enable      : clock enable; low freezes all state and outputs
//   ser         : serial pins + status (slave modport)
//   *_flat      : per-neuron active parameters, neuron i at [i*W +: W]
// Frame: header byte (bit7 broadcast, bits[6:0] address) then WA, WB, LEAK,
// THRESH, CYC bytes, MSB first. Build option LIF_LOADER_PARITY_EN appends a
// 49th even-parity bit over the preceding 48 bits.
module lif_neuron_param_loader_multi
   import lif_loader_pkg::*;
#(
   parameter int NUM_NEURONS = 4,
   parameter int W_WEIGHT    = 3,
   parameter int W_LEAK      = 8,
   parameter int W_THRESH    = 8,
   parameter int W_CYC       = 4,
   parameter int DEF_WA      = 2,
   parameter int DEF_WB      = 2,
   parameter int DEF_LEAK    = 2,
   parameter int DEF_THRESH  = 30,
   parameter int DEF_CYC     = 2
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            enable,
   lif_neuron_param_loader_multi_if.slave  ser,
   output logic [NUM_NEURONS*W_WEIGHT-1:0] weight_a_flat,
   output logic [NUM_NEURONS*W_WEIGHT-1:0] weight_b_flat,
   output logic [NUM_NEURONS*W_LEAK-1:0]   leak_rate_flat,
   output logic [NUM_NEURONS*W_THRESH-1:0] threshold_flat,
   output logic [NUM_NEURONS*W_CYC-1:0]    leak_cycles_flat
);

   state_e              state_q, state_d;
   logic [6:0]          shift_q, shift_d;
   logic [2:0]          bit_cnt_q, bit_cnt_d;
   logic [2:0]          fld_q, fld_d;
   logic [7:0]          hdr_q, hdr_d;
   logic [W_WEIGHT-1:0] wa_sh_q, wa_sh_d, wb_sh_q, wb_sh_d;
   logic [W_LEAK-1:0]   leak_sh_q, leak_sh_d;
   logic [W_THRESH-1:0] thr_sh_q, thr_sh_d;
   logic                ready_q, ready_d;
   logic                done_q, done_d;
   logic                err_q, err_d;

   logic [7:0]          byte_d;
   logic                last_bit;
   logic                addr_ok;
   logic                frame_ok;
   logic                commit;
   logic [W_CYC-1:0]    cyc_commit;

   // Byte including the bit sampled this cycle.
   assign byte_d  = {shift_q, ser.serial_data_in};
   assign addr_ok = hdr_q[BCAST_BIT] | (32'(hdr_q[6:0]) < NUM_NEURONS);

`ifdef LIF_LOADER_PARITY_EN
   logic             par_q, par_d;
   logic [W_CYC-1:0] cyc_sh_q, cyc_sh_d;

   // Parity bit is the only bit of pseudo-field NUM_FIELDS.
   assign last_bit   = (fld_q == 3'(NUM_FIELDS));
   // Even parity: XOR of all 49 bits must be zero.
   assign frame_ok   = addr_ok & ~(par_q ^ ser.serial_data_in);
   assign cyc_commit = cyc_sh_q;
`else
   assign last_bit   = (fld_q == FLD_CYC) && (bit_cnt_q == 3'd7);
   assign frame_ok   = addr_ok;
   // CYC byte completes on the committing edge, so it bypasses the shadow.
   assign cyc_commit = byte_d[W_CYC-1:0];
`endif

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      fld_d     = fld_q;
      hdr_d     = hdr_q;
      wa_sh_d   = wa_sh_q;
      wb_sh_d   = wb_sh_q;
      leak_sh_d = leak_sh_q;
      thr_sh_d  = thr_sh_q;
      ready_d   = ready_q;
      done_d    = done_q;
      err_d     = err_q;
      commit    = 1'b0;
`ifdef LIF_LOADER_PARITY_EN
      par_d     = par_q;
      cyc_sh_d  = cyc_sh_q;
`endif
      if (enable) begin
         done_d = 1'b0;
         err_d  = 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (ser.load_enable) begin
                  state_d   = ST_HEADER;
                  ready_d   = 1'b0;
                  shift_d   = '0;
                  bit_cnt_d = '0;
                  fld_d     = '0;
`ifdef LIF_LOADER_PARITY_EN
                  par_d     = 1'b0;
`endif
               end
            end
            ST_HEADER, ST_FIELD: begin
               if (!ser.load_enable) begin
                  // Abort: shadow is simply abandoned.
                  state_d = ST_IDLE;
                  err_d   = 1'b1;
                  ready_d = 1'b1;
               end else begin
                  shift_d   = byte_d[6:0];
                  bit_cnt_d = bit_cnt_q + 3'd1;
`ifdef LIF_LOADER_PARITY_EN
                  par_d     = par_q ^ ser.serial_data_in;
`endif
                  if (state_q == ST_HEADER) begin
                     if (bit_cnt_q == 3'd7) begin
                        hdr_d   = byte_d;
                        state_d = ST_FIELD;
                        fld_d   = FLD_WA;
                     end
                  end else if (last_bit) begin
                     commit  = frame_ok;
                     done_d  = frame_ok;
                     err_d   = ~frame_ok;
                     ready_d = 1'b1;
                     state_d = ST_WAIT_RELEASE;
                  end else if (bit_cnt_q == 3'd7) begin
                     case (fld_q)
                        FLD_WA:     wa_sh_d   = byte_d[W_WEIGHT-1:0];
                        FLD_WB:     wb_sh_d   = byte_d[W_WEIGHT-1:0];
                        FLD_LEAK:   leak_sh_d = byte_d[W_LEAK-1:0];
                        FLD_THRESH: thr_sh_d  = byte_d[W_THRESH-1:0];
`ifdef LIF_LOADER_PARITY_EN
                        FLD_CYC:    cyc_sh_d  = byte_d[W_CYC-1:0];
`endif
                        default: ;
                     endcase
                     fld_d = fld_q + 3'd1;
                  end
               end
            end
            ST_WAIT_RELEASE: begin
               // Trailing bits are ignored until the gate drops.
               if (!ser.load_enable) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         fld_q     <= '0;
         hdr_q     <= '0;
         wa_sh_q   <= '0;
         wb_sh_q   <= '0;
         leak_sh_q <= '0;
         thr_sh_q  <= '0;
         ready_q   <= 1'b1;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         fld_q     <= fld_d;
         hdr_q     <= hdr_d;
         wa_sh_q   <= wa_sh_d;
         wb_sh_q   <= wb_sh_d;
         leak_sh_q <= leak_sh_d;
         thr_sh_q  <= thr_sh_d;
         ready_q   <= ready_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

`ifdef LIF_LOADER_PARITY_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         par_q    <= 1'b0;
         cyc_sh_q <= '0;
      end else begin
         par_q    <= par_d;
         cyc_sh_q <= cyc_sh_d;
      end
   end
`endif

   assign ser.params_ready = ready_q;
   assign ser.frame_done   = done_q;
   assign ser.frame_error  = err_q;

   for (genvar i = 0; i < NUM_NEURONS; i++) begin : g_bank
      logic sel;
      assign sel = commit & (hdr_q[BCAST_BIT] | (hdr_q[6:0] == 7'(i)));

      lif_param_bank #(
         .W_WEIGHT   (W_WEIGHT),
         .W_LEAK     (W_LEAK),
         .W_THRESH   (W_THRESH),
         .W_CYC      (W_CYC),
         .DEF_WA     (DEF_WA),
         .DEF_WB     (DEF_WB),
         .DEF_LEAK   (DEF_LEAK),
         .DEF_THRESH (DEF_THRESH),
         .DEF_CYC    (DEF_CYC)
      ) u_bank (
         .clk       (clk),
         .reset     (reset),
         .commit    (sel),
         .sh_wa     (wa_sh_q),
         .sh_wb     (wb_sh_q),
         .sh_leak   (leak_sh_q),
         .sh_thresh (thr_sh_q),
         .sh_cyc    (cyc_commit),
         .wa        (weight_a_flat[i*W_WEIGHT +: W_WEIGHT]),
         .wb        (weight_b_flat[i*W_WEIGHT +: W_WEIGHT]),
         .leak      (leak_rate_flat[i*W_LEAK +: W_LEAK]),
         .thresh    (threshold_flat[i*W_THRESH +: W_THRESH]),
         .cyc       (leak_cycles_flat[i*W_CYC +: W_CYC])
      );
   end

endmodule
